br_btb_predictor: RTL and testbench

- Fetch-stage dynamic branch predictor: a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- Each cycle it looks up the IF-stage PC and produces a predicted next PC.
- It is trained by the EX-stage branch resolution unit, which reports each resolved branch or jump and whether it mispredicted.
- Replaces the static always-taken scheme; the EX resolver's mispredict/flush path is unchanged.

---
 rtl/br_btb_predictor_if.sv | 30 +++
 rtl/br_btb_predictor.sv | 105 ++++++++++
 tb/tb_br_btb_predictor.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/br_btb_predictor_if.sv
// Fetch-lookup, EX-training and statistics signals of the BTB predictor.
// The master side is the pipeline (fetch + EX resolver); the slave side is the predictor.
interface br_btb_predictor_if;
  logic [31:0] i_pc_IF;
  logic        o_hit;
  logic        o_pred_taken;
  logic [31:0] o_pred_target;
  logic [31:0] o_pc_next;
  logic        i_upd_valid;
  logic [31:0] i_upd_pc;
  logic        i_upd_is_branch;
  logic        i_upd_is_jump;
  logic        i_upd_taken;
  logic [31:0] i_upd_target;
  logic        i_upd_mispred;
  logic [31:0] o_br_cnt;
  logic [31:0] o_mispred_cnt;

  modport master (
    output i_pc_IF, i_upd_valid, i_upd_pc, i_upd_is_branch, i_upd_is_jump,
           i_upd_taken, i_upd_target, i_upd_mispred,
    input  o_hit, o_pred_taken, o_pred_target, o_pc_next, o_br_cnt, o_mispred_cnt
  );

  modport slave (
    input  i_pc_IF, i_upd_valid, i_upd_pc, i_upd_is_branch, i_upd_is_jump,
           i_upd_taken, i_upd_target, i_upd_mispred,
    output o_hit, o_pred_taken, o_pred_target, o_pc_next, o_br_cnt, o_mispred_cnt
  );
endinterface

// File: rtl/br_btb_predictor.sv
// Direct-mapped BTB with 2-bit counters: zero-latency lookup from registered state, trained one edge later.
// No backpressure: lookup is pure and the pipeline gates i_upd_valid.
module br_btb_predictor #(
  parameter  int ENTRIES = 16,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  br_btb_predictor_if.slave btb
);

  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0]            valid_q,  valid_d;
  logic [ENTRIES-1:0][TAG_W-1:0] tag_q,    tag_d;
  logic [ENTRIES-1:0][31:0]      target_q, target_d;
  logic [ENTRIES-1:0][1:0]       ctr_q,    ctr_d;
  logic [ENTRIES-1:0]            jmp_q,    jmp_d;
  logic [31:0]                   br_cnt_q, br_cnt_d;
  logic [31:0]                   mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             upd_qual, upd_hit;
  logic             unused_pc_lsbs;

  assign lk_idx   = btb.i_pc_IF[IDX_W+1:2];
  assign lk_tag   = btb.i_pc_IF[31:IDX_W+2];
  assign upd_idx  = btb.i_upd_pc[IDX_W+1:2];
  assign upd_tag  = btb.i_upd_pc[31:IDX_W+2];
  assign upd_qual = btb.i_upd_valid & (btb.i_upd_is_branch | btb.i_upd_is_jump);
  assign upd_hit  = valid_q[upd_idx] & (tag_q[upd_idx] == upd_tag);

  assign unused_pc_lsbs = ^{btb.i_pc_IF[1:0], btb.i_upd_pc[1:0]};

  // Lookup sees only registered state, so a same-cycle update is visible next cycle.
  always_comb begin
    btb.o_hit         = valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
    btb.o_pred_taken  = btb.o_hit & (jmp_q[lk_idx] | ctr_q[lk_idx][1]);
    btb.o_pred_target = btb.o_hit ? target_q[lk_idx] : 32'd0;
    btb.o_pc_next     = btb.o_pred_taken ? btb.o_pred_target : btb.i_pc_IF + 32'd4;
  end

  assign btb.o_br_cnt      = br_cnt_q;
  assign btb.o_mispred_cnt = mispred_cnt_q;

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    jmp_d    = jmp_q;
    if (upd_qual) begin
      if (upd_hit) begin
        if (btb.i_upd_is_jump) begin
          ctr_d[upd_idx]    = 2'b11;
          jmp_d[upd_idx]    = 1'b1;
          target_d[upd_idx] = btb.i_upd_target;
        end else if (btb.i_upd_taken) begin
          if (ctr_q[upd_idx] != 2'b11) ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
          target_d[upd_idx] = btb.i_upd_target;
        end else begin
          if (ctr_q[upd_idx] != 2'b00) ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
        end
      end else if (btb.i_upd_taken | btb.i_upd_is_jump) begin
        // Not-taken branches that miss are never allocated.
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = btb.i_upd_target;
        ctr_d[upd_idx]    = btb.i_upd_is_jump ? 2'b11 : 2'b10;
        jmp_d[upd_idx]    = btb.i_upd_is_jump;
      end
    end
  end

  always_comb begin
    br_cnt_d      = br_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (upd_qual) begin
      br_cnt_d = br_cnt_q + 32'd1;
      if (btb.i_upd_mispred) mispred_cnt_d = mispred_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_q       <= '0;
      tag_q         <= '0;
      target_q      <= '0;
      ctr_q         <= '0;
      jmp_q         <= '0;
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else begin
      valid_q       <= valid_d;
      tag_q         <= tag_d;
      target_q      <= target_d;
      ctr_q         <= ctr_d;
      jmp_q         <= jmp_d;
      br_cnt_q      <= br_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

endmodule

// File: tb/tb_br_btb_predictor.sv
// Vector-table bench for br_btb_predictor: each row is one cycle of fetch lookup plus optional EX update.
// Outputs are sampled 1 ns after the falling edge, i.e. before that row's update lands.
module tb_br_btb_predictor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  br_btb_predictor_if btb_if ();

  br_btb_predictor #(.ENTRIES(16)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .btb     (btb_if)
  );

  typedef struct {
    logic        rst_n;
    logic [31:0] pc;
    logic        uv;
    logic [31:0] upc;
    logic        br;
    logic        jmp;
    logic        tk;
    logic [31:0] tgt;
    logic        mp;
    logic        chk;
    logic        hit;
    logic        ptk;
    logic [31:0] etgt;
    logic [31:0] nxt;
    logic [31:0] bc;
    logic [31:0] mc;
  } vec_t;

  typedef struct {
    int          row;
    logic        hit;
    logic        ptk;
    logic [31:0] etgt;
    logic [31:0] nxt;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_n                  = v.rst_n;
    btb_if.i_pc_IF         = v.pc;
    btb_if.i_upd_valid     = v.uv;
    btb_if.i_upd_pc        = v.upc;
    btb_if.i_upd_is_branch = v.br;
    btb_if.i_upd_is_jump   = v.jmp;
    btb_if.i_upd_taken     = v.tk;
    btb_if.i_upd_target    = v.tgt;
    btb_if.i_upd_mispred   = v.mp;
  endtask

  task automatic compare(input exp_t e);
    chk32($sformatf("row%0d hit", e.row),    {31'd0, btb_if.o_hit},        {31'd0, e.hit});
    chk32($sformatf("row%0d taken", e.row),  {31'd0, btb_if.o_pred_taken}, {31'd0, e.ptk});
    chk32($sformatf("row%0d target", e.row), btb_if.o_pred_target,         e.etgt);
    chk32($sformatf("row%0d pc_next", e.row), btb_if.o_pc_next,            e.nxt);
    chk32($sformatf("row%0d br_cnt", e.row), btb_if.o_br_cnt,              e.bc);
    chk32($sformatf("row%0d mis_cnt", e.row), btb_if.o_mispred_cnt,        e.mc);
  endtask

  task automatic run_row(input int i, input vec_t v);
    exp_t e;
    @(negedge clk);
    drive(v);
    if (v.chk) sb.push_back('{i, v.hit, v.ptk, v.etgt, v.nxt, v.bc, v.mc});
    #1;
    if (v.chk) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL row%0d scoreboard: got empty queue expected entry", i);
      end else begin
        e = sb.pop_front();
        compare(e);
      end
    end
  endtask

  initial begin
    exp_t e;
    //              rst pc            uv upc           br jmp tk tgt           mp chk hit ptk etgt          nxt           bc      mc
    vecs.push_back('{0, 32'h100,      0, 32'h0,      0, 0, 0, 32'h0,     0, 0, 0, 0, 32'h0,   32'h0,       32'd0,  32'd0}); // 0
    vecs.push_back('{1, 32'h100,      0, 32'h0,      0, 0, 0, 32'h0,     0, 1, 0, 0, 32'h0,   32'h104,     32'd0,  32'd0}); // 1
    vecs.push_back('{1, 32'h100,      1, 32'h100,    1, 0, 1, 32'h80,    1, 1, 0, 0, 32'h0,   32'h104,     32'd0,  32'd0}); // 2
    vecs.push_back('{1, 32'h100,      0, 32'h0,      0, 0, 0, 32'h0,     0, 1, 1, 1, 32'h80,  32'h80,      32'd1,  32'd1}); // 3
    vecs.push_back('{1, 32'h100,      1, 32'h100,    1, 0, 0, 32'h0,     1, 1, 1, 1, 32'h80,  32'h80,      32'd1,  32'd1}); // 4
    vecs.push_back('{1, 32'h100,      1, 32'h100,    1, 0, 0, 32'h0,     0, 1, 1, 0, 32'h80,  32'h104,     32'd2,  32'd2}); // 5
    vecs.push_back('{1, 32'h100,      1, 32'h100,    1, 0, 1, 32'h80,    1, 1, 1, 0, 32'h80,  32'h104,     32'd3,  32'd2}); // 6
    vecs.push_back('{1, 32'h100,      1, 32'h100,    1, 0, 1, 32'h80,    1, 1, 1, 0, 32'h80,  32'h104,     32'd4,  32'd3}); // 7
    vecs.push_back('{1, 32'h100,      1, 32'h100,    1, 0, 1, 32'h80,    0, 1, 1, 1, 32'h80,  32'h80,      32'd5,  32'd4}); // 8
    vecs.push_back('{1, 32'h100,      1, 32'h100,    1, 0, 1, 32'h80,    0, 1, 1, 1, 32'h80,  32'h80,      32'd6,  32'd4}); // 9
    vecs.push_back('{1, 32'h100,      1, 32'h100,    1, 0, 0, 32'h0,     1, 1, 1, 1, 32'h80,  32'h80,      32'd7,  32'd4}); // 10
    vecs.push_back('{1, 32'h100,      1, 32'h100,    0, 0, 1, 32'h999,   1, 1, 1, 1, 32'h80,  32'h80,      32'd8,  32'd5}); // 11
    vecs.push_back('{1, 32'h100,      0, 32'h100,    1, 0, 0, 32'h0,     1, 1, 1, 1, 32'h80,  32'h80,      32'd8,  32'd5}); // 12
    vecs.push_back('{1, 32'h100,      0, 32'h0,      0, 0, 0, 32'h0,     0, 1, 1, 1, 32'h80,  32'h80,      32'd8,  32'd5}); // 13
    vecs.push_back('{1, 32'h140,      1, 32'h140,    0, 1, 1, 32'h400,   1, 1, 0, 0, 32'h0,   32'h144,     32'd8,  32'd5}); // 14
    vecs.push_back('{1, 32'h100,      0, 32'h0,      0, 0, 0, 32'h0,     0, 1, 0, 0, 32'h0,   32'h104,     32'd9,  32'd6}); // 15
    vecs.push_back('{1, 32'h140,      0, 32'h0,      0, 0, 0, 32'h0,     0, 1, 1, 1, 32'h400, 32'h400,     32'd9,  32'd6}); // 16
    vecs.push_back('{1, 32'h200,      1, 32'h200,    1, 0, 1, 32'h10,    1, 1, 0, 0, 32'h0,   32'h204,     32'd9,  32'd6}); // 17
    vecs.push_back('{1, 32'h200,      0, 32'h0,      0, 0, 0, 32'h0,     0, 1, 1, 1, 32'h10,  32'h10,      32'd10, 32'd7}); // 18
    vecs.push_back('{1, 32'h300,      1, 32'h300,    1, 0, 0, 32'h0,     0, 1, 0, 0, 32'h0,   32'h304,     32'd10, 32'd7}); // 19
    vecs.push_back('{1, 32'h300,      0, 32'h0,      0, 0, 0, 32'h0,     0, 1, 0, 0, 32'h0,   32'h304,     32'd11, 32'd7}); // 20
    vecs.push_back('{1, 32'h200,      0, 32'h0,      0, 0, 0, 32'h0,     0, 1, 1, 1, 32'h10,  32'h10,      32'd11, 32'd7}); // 21
    vecs.push_back('{1, 32'h104,      1, 32'h104,    0, 1, 1, 32'h500,   0, 1, 0, 0, 32'h0,   32'h108,     32'd11, 32'd7}); // 22
    vecs.push_back('{1, 32'h104,      0, 32'h0,      0, 0, 0, 32'h0,     0, 1, 1, 1, 32'h500, 32'h500,     32'd12, 32'd7}); // 23
    vecs.push_back('{1, 32'hFFFFFFFC, 0, 32'h0,      0, 0, 0, 32'h0,     0, 1, 0, 0, 32'h0,   32'h0,       32'd12, 32'd7}); // 24
    vecs.push_back('{0, 32'h104,      1, 32'h104,    0, 1, 1, 32'h700,   1, 1, 1, 1, 32'h500, 32'h500,     32'd12, 32'd7}); // 25
    vecs.push_back('{1, 32'h104,      0, 32'h0,      0, 0, 0, 32'h0,     0, 1, 0, 0, 32'h0,   32'h108,     32'd0,  32'd0}); // 26
    vecs.push_back('{1, 32'h200,      0, 32'h0,      0, 0, 0, 32'h0,     0, 1, 0, 0, 32'h0,   32'h204,     32'd0,  32'd0}); // 27
    vecs.push_back('{1, 32'h100,      0, 32'h0,      0, 0, 0, 32'h0,     0, 1, 0, 0, 32'h0,   32'h104,     32'd0,  32'd0}); // 28

    for (int i = 0; i < vecs.size(); i++) run_row(i, vecs[i]);

    // Counter wrap: preload both counters to all-ones, then one mispredicted update wraps both to 0.
    @(negedge clk);
    drive('{1, 32'h100, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 32'd0, 32'd0});
    force dut.br_cnt_d      = 32'hFFFF_FFFF;
    force dut.mispred_cnt_d = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.br_cnt_d;
    release dut.mispred_cnt_d;
    drive('{1, 32'h100, 1, 32'h100, 1, 0, 1, 32'h80, 1, 0, 0, 0, 32'h0, 32'h0, 32'd0, 32'd0});
    sb.push_back('{100, 1'b0, 1'b0, 32'h0, 32'h104, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    #1;
    e = sb.pop_front();
    compare(e);
    @(negedge clk);
    drive('{1, 32'h100, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 32'd0, 32'd0});
    sb.push_back('{101, 1'b1, 1'b1, 32'h80, 32'h80, 32'd0, 32'd0});
    #1;
    e = sb.pop_front();
    compare(e);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
